priority_decoder: RTL and testbench
===================================

PRIORITY_DECODER -- requirements
Module: priority_decoder

Parameters
REQ-001 The block SHALL provide parameter DEPTH, default 2, meaning the number of buffer entries (power of two, minimum 2).
REQ-002 The block SHALL provide parameter CNT_W, default 8, meaning the width of the statistics counters.

Interface
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer has an encoded symbol.
REQ-006 in_q  input  2  encoded index of the highest set bit.
REQ-007 in_nz  input  1  encoder valid flag; 0 means the original vector was all-zero.
REQ-008 in_ready  output  1  block can accept a symbol this cycle.
REQ-009 out_valid  output  1  out_d holds a decoded vector.
REQ-010 out_d  output  4  decoded one-hot vector.
REQ-011 out_ready  input  1  consumer accepts out_d this cycle.
REQ-012 xfer_cnt  output  CNT_W  count of completed output transfers.
REQ-013 zero_cnt  output  CNT_W  count of completed output transfers with out_d == 4'b0000.

Function
REQ-014 The block SHALL accept a symbol (push) on a rising edge when in_valid && in_ready; it SHALL store {in_nz, in_q} in a DEPTH-entry circular FIFO.
REQ-015 The block SHALL complete an output transfer (pop) on a rising edge when out_valid && out_ready.
REQ-016 in_ready SHALL equal (occupancy < DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (occupancy != 0).
REQ-018 out_d SHALL be decoded from the head entry: in_nz=1 -> out_d = 4'b0001 << in_q; in_nz=0 -> out_d = 4'b0000, regardless of in_q.
REQ-019 Latency SHALL be exactly one cycle: a symbol pushed at edge N SHALL appear on out_valid/out_d after edge N, with no same-cycle pass-through.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged, with both pointers advancing.
REQ-021 When full, in_ready SHALL be 0 and in_valid SHALL be ignored, with no overwrite.
REQ-022 When empty, out_ready SHALL be ignored, and the pointers and occupancy SHALL NOT change.
REQ-023 The read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH, tracked in log2(DEPTH)+1 bits.
REQ-024 out_d and the head entry SHALL remain stable while out_valid && !out_ready.
REQ-025 On each pop, xfer_cnt SHALL increment by 1 and wrap from 2^CNT_W-1 to 0.
REQ-026 On each pop with out_d == 0, zero_cnt SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-027 Encoder round-trip: for any nonzero 4-bit vector V, the pair (priority index of V, nz=1) SHALL decode to the highest set bit of V only.

Reset
REQ-028 While rst=0, the block SHALL immediately, without waiting for clk, clear occupancy, both pointers, xfer_cnt and zero_cnt, drive out_valid=0 and out_d=4'b0000, and hold in_ready=0.
REQ-029 On rst release, in_ready SHALL be 1 from the first rising edge after release; no push SHALL occur on the edge coincident with release.
REQ-030 Reset asserted mid-operation SHALL discard all buffered symbols; no stale entry SHALL appear after release.
REQ-031 FIFO storage contents need not be reset, but out_d SHALL read 0 whenever out_valid=0.

Verification
REQ-032 Single push, then drain: in_q=2, in_nz=1, out_ready=1 -> one cycle later out_valid=1, out_d=4'b0100; xfer_cnt=1.
REQ-033 All-zero symbol: in_nz=0, in_q=3 -> out_d=4'b0000 on pop; zero_cnt=1, xfer_cnt=1.
REQ-034 Back-pressure: out_ready=0, push q=0,1,2 -> in_ready=0 after 2 pushes (DEPTH=2) and the 3rd symbol is not accepted; release out_ready -> out_d=0001 then 0010, in order.
REQ-035 Streaming: in_valid=1 and out_ready=1 continuously with q=0..3 cycling -> occupancy stays 1 and one output per cycle follows 0001, 0010, 0100, 1000 after one cycle of latency.
REQ-036 Counter limits, with CNT_W=4: 17 pops of nz=0 -> xfer_cnt=1 (wrapped), zero_cnt=15 (saturated).
REQ-037 Reset mid-stream: assert rst=0 with 2 entries buffered -> out_valid=0, out_d=0, counters=0 immediately; after release -> out_valid stays 0 until a new push.

Source files
------------

// File: rtl/priority_decoder.sv
// Buffered one-hot decoder for {nz, index} symbols from a priority encoder.
// DEPTH-entry circular FIFO with transfer and all-zero statistics counters.
module priority_decoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_q,
  input  logic             in_nz,
  output logic             in_ready,
  output logic             out_valid,
  output logic [3:0]       out_d,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] zero_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [2:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ready_en_q;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic [CNT_W-1:0] zero_q, zero_d;
  logic [2:0]       head;
  logic             push, pop;

  // ready_en_q keeps in_ready low through reset and the edge coincident with release
  assign in_ready  = ready_en_q && (count_q < FULL_LVL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head  = mem_q[rd_ptr_q];
  assign out_d = (out_valid && head[2]) ? (4'b0001 << head[1:0]) : 4'b0000;

  assign xfer_cnt = xfer_q;
  assign zero_cnt = zero_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    xfer_d   = xfer_q;
    zero_d   = zero_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      xfer_d   = xfer_q + 1'b1;
      if ((out_d == 4'b0000) && (zero_q != '1)) zero_d = zero_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      xfer_q     <= '0;
      zero_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
      xfer_q     <= xfer_d;
      zero_q     <= zero_d;
    end
  end

  // Storage is not reset; out_d is masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_nz, in_q};
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder: a negedge monitor tracks an ideal
// queue of expected one-hot outputs and compares every DUT output against it.
module tb_priority_decoder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [1:0]       in_q;
  logic             in_nz;
  logic             in_ready;
  logic             out_valid;
  logic [3:0]       out_d;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] zero_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned exp_q[$];
  int unsigned cur_exp  = 0;
  int unsigned m_xfer   = 0;
  int unsigned m_zero   = 0;
  bit          m_rdy_en = 0;

  priority_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_q(in_q), .in_nz(in_nz),
    .in_ready(in_ready), .out_valid(out_valid), .out_d(out_d),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt), .zero_cnt(zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare against the ideal queue, then advance the model for the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_d", out_d, 0);
      chk("rst_xfer", xfer_cnt, 0);
      chk("rst_zero", zero_cnt, 0);
      exp_q.delete();
      m_xfer = 0;
      m_zero = 0;
      m_rdy_en = 0;
    end else begin
      bit rdy;
      int unsigned head;
      rdy  = m_rdy_en && (exp_q.size() < DEPTH);
      head = (exp_q.size() != 0) ? exp_q[0] : 0;
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("out_d", out_d, head);
      chk("xfer_cnt", xfer_cnt, m_xfer);
      chk("zero_cnt", zero_cnt, m_zero);
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        m_xfer = (m_xfer + 1) % (CMAX + 1);
        if (head == 0 && m_zero < CMAX) m_zero++;
      end
      if (in_valid && rdy) exp_q.push_back(cur_exp);
      m_rdy_en = 1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sym(input int unsigned q, input bit nz);
    in_q    = 2'(q);
    in_nz   = nz;
    cur_exp = nz ? (1 << q) : 0;
  endtask

  // Symbol from a raw vector: encoder index of its top bit, expectation = largest power of two <= v.
  task automatic sym_vec(input int unsigned v);
    int unsigned p;
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (v & (1 << i)) idx = i;
    p = 1;
    while (p * 2 <= v) p = p * 2;
    in_nz   = (v != 0);
    in_q    = (v != 0) ? 2'(idx) : 2'($urandom_range(0, 3));
    cur_exp = (v != 0) ? p : 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("imm_out_valid", out_valid, 0);
    chk("imm_out_d", out_d, 0);
    chk("imm_xfer", xfer_cnt, 0);
    chk("imm_zero", zero_cnt, 0);
    chk("imm_in_ready", in_ready, 0);
    cyc(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sym(0, 0);
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // single push then drain
    out_ready = 1'b1; in_valid = 1'b1; sym(2, 1);
    cyc(1);
    in_valid = 1'b0;
    chk("single_out_d", out_d, 4'b0100);
    cyc(1);
    chk("single_xfer", xfer_cnt, 1);

    // all-zero symbol with a nonzero index
    in_valid = 1'b1; sym(3, 0);
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    chk("zero_sym_zero_cnt", zero_cnt, 1);
    chk("zero_sym_xfer", xfer_cnt, 2);

    // back-pressure: third symbol must be refused while full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sym(i, 1);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("bp_full_ready", in_ready, 0);
    out_ready = 1'b1;
    chk("bp_first", out_d, 4'b0001);
    cyc(1);
    chk("bp_second", out_d, 4'b0010);
    cyc(2);
    chk("bp_drained", out_valid, 0);

    // streaming at full rate
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sym(i % 4, 1);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(2);

    // counter limits: 17 all-zero pops after a fresh reset
    do_reset();
    cyc(1);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sym($urandom_range(0, 3), 0);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(2);
    chk("lim_xfer_wrap", xfer_cnt, 1);
    chk("lim_zero_sat", zero_cnt, CMAX);

    // randomized traffic, symbols derived from random 4-bit vectors
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sym_vec($urandom_range(0, 15));
      cyc(1);
    end

    // reset with two entries buffered
    in_valid = 1'b1; out_ready = 1'b0;
    sym(1, 1); cyc(1);
    sym(3, 1); cyc(1);
    in_valid = 1'b0;
    chk("mid_buffered", out_valid, 1);
    do_reset();
    cyc(4);
    chk("post_rst_empty", out_valid, 0);
    out_ready = 1'b1; in_valid = 1'b1; sym(3, 1);
    cyc(1);
    in_valid = 1'b0;
    chk("post_rst_new", out_d, 4'b1000);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
